sram_sync_nxm: RTL

SRAM_SYNC_NXM -- requirements
Module: sram_sync_nxm

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_core.sv | 36 +++
 rtl/sram_sync_nxm.sv | 114 +++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared FSM state type and parity helper for sram_sync_nxm
package sram_pkg;

  // INIT sweeps the array with the init value; IDLE serves accesses until reset
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } sram_state_e;

  // Widest data word the parity helper accepts; callers zero-extend into it
  localparam int PAR_MAX_W = 64;

  // Even parity bit: makes the total count of ones (data + bit) even
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sram_core.sv
// rtl/sram_core.sv - clocked single-port word array with registered read port
module sram_core #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rdata_q;

  // Array write; the array itself has no reset, contents are set by the sweep
  always_ff @(posedge clk_i) begin
    if (resetn_i && en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only loads on a read, so it holds across writes and idle cycles
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_sync_nxm.sv
// rtl/sram_sync_nxm.sv - init-swept synchronous SRAM wrapper; SRAM_PARITY_EN adds per-word parity
module sram_sync_nxm
  import sram_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic              CE_n,
  input  logic              WE_n,
  input  logic [DATA_W-1:0] D_IN,
  output logic [DATA_W-1:0] D_OUT,
  output logic              D_VALID,
  output logic              BUSY,
  input  logic              PAR_INJ,
  output logic              PAR_ERR
);

`ifdef SRAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              valid_q;
  logic              rd_fire;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] init_word;
  logic [WORD_W-1:0] user_word;

`ifdef SRAM_PARITY_EN
  // Sweep always stores good parity; user writes may flip it for error injection
  assign init_word = {even_par(PAR_MAX_W'(INIT_VAL)), INIT_VAL};
  assign user_word = {even_par(PAR_MAX_W'(D_IN)) ^ PAR_INJ, D_IN};
  assign PAR_ERR   = valid_q & (rd_word[DATA_W] ^ even_par(PAR_MAX_W'(rd_word[DATA_W-1:0])));
`else
  logic unused_par_inj;
  assign unused_par_inj = PAR_INJ;
  assign init_word      = INIT_VAL;
  assign user_word      = D_IN;
  assign PAR_ERR        = 1'b0;
`endif

  assign D_OUT   = rd_word[DATA_W-1:0];
  assign D_VALID = valid_q;
  assign BUSY    = (state_q == INIT);

  // Next state and array port mux: the sweep owns the port in INIT, the user in IDLE
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = A;
    mem_wdata = user_word;
    rd_fire   = 1'b0;
    unique case (state_q)
      INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = init_word;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == '1) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        mem_en  = ~CE_n;
        mem_we  = ~WE_n;
        rd_fire = ~CE_n & WE_n;
      end
      default: state_d = INIT;
    endcase
  end

  // State, sweep pointer and read-valid flag; reset restarts the sweep and drops any read
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= rd_fire;
    end
  end

  sram_core #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_core (
    .clk_i   (sysclk),
    .resetn_i(sys_rst_n),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (rd_word)
  );

endmodule
